// File: rtl/nios_ii_system_pio_pkg.sv
// Shared definitions for the NIOS II system PIO blocks: register map,
// STATUS bit positions and the one-shot timer state encoding.
package nios_ii_system_pio_pkg;

  localparam logic [2:0] ADDR_DATA      = 3'd0;
  localparam logic [2:0] ADDR_OUTSET    = 3'd1;
  localparam logic [2:0] ADDR_OUTCLR    = 3'd2;
  localparam logic [2:0] ADDR_PULSE_LEN = 3'd3;
  localparam logic [2:0] ADDR_PULSE     = 3'd4;
  localparam logic [2:0] ADDR_IRQ_EN    = 3'd5;
  localparam logic [2:0] ADDR_STATUS    = 3'd6;

  localparam int STATUS_DONE    = 0;
  localparam int STATUS_BUSY    = 1;
  localparam int STATUS_OVERRUN = 2;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } timer_state_e;

endpackage

// File: rtl/nios_ii_system_pulse_timer.sv
// One-shot pulse timer: loads a length on start, counts down to 1, then
// returns to IDLE. Reports completion and ignored (overrun) starts as
// single-cycle strobes valid on the edge they take effect.
module nios_ii_system_pulse_timer
  import nios_ii_system_pio_pkg::*;
#(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [CNT_WIDTH-1:0] len,
  output logic                 active,
  output logic                 done_pulse,
  output logic                 overrun_pulse
);

  timer_state_e         state;
  logic [CNT_WIDTH-1:0] cnt;

  assign active        = (state == ACTIVE);
  // Completion: last count of a running pulse, or a zero-length start.
  assign done_pulse    = ((state == ACTIVE) && (cnt == CNT_WIDTH'(1))) ||
                         ((state == IDLE) && start && (len == '0));
  // A start while running is dropped; the running pulse is not restarted.
  assign overrun_pulse = (state == ACTIVE) && start;

  // FSM and down-counter; the counter stops at 1 so it can never wrap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      unique case (state)
        IDLE: begin
          if (start && (len != '0)) begin
            state <= ACTIVE;
            cnt   <= len;
          end
        end
        ACTIVE: begin
          if (cnt == CNT_WIDTH'(1)) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt - CNT_WIDTH'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/nios_ii_system_led_pulse.sv
// Avalon-MM output port with data register, atomic set/clear and a
// one-shot pulse that inverts selected bits for a programmed number of
// clocks, then raises a maskable completion interrupt.
module nios_ii_system_led_pulse
  import nios_ii_system_pio_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter int               CNT_WIDTH   = 16,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             irq,
  output logic [WIDTH-1:0] out_port
);

  logic                 wr_en;
  logic [WIDTH-1:0]     data;
  logic [WIDTH-1:0]     mask;
  logic [CNT_WIDTH-1:0] pulse_len;
  logic                 irq_en;
  logic                 done;
  logic                 overrun;
  logic                 start;
  logic                 active;
  logic                 done_pulse;
  logic                 overrun_pulse;
  logic [31:0]          rd_next;
  logic                 unused_writedata;

  assign wr_en            = chipselect && !write_n;
  assign start            = wr_en && (address == ADDR_PULSE);
  assign irq              = done && irq_en;
  assign unused_writedata = ^writedata;

  nios_ii_system_pulse_timer #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_timer (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .len          (pulse_len),
    .active       (active),
    .done_pulse   (done_pulse),
    .overrun_pulse(overrun_pulse)
  );

  // Register file, pulse mask and sticky status; a set beats a clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data      <= RESET_VALUE;
      mask      <= '0;
      pulse_len <= '0;
      irq_en    <= 1'b0;
      done      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (wr_en) begin
        unique case (address)
          ADDR_DATA:      data      <= writedata[WIDTH-1:0];
          ADDR_OUTSET:    data      <= data | writedata[WIDTH-1:0];
          ADDR_OUTCLR:    data      <= data & ~writedata[WIDTH-1:0];
          ADDR_PULSE_LEN: pulse_len <= writedata[CNT_WIDTH-1:0];
          ADDR_IRQ_EN:    irq_en    <= writedata[0];
          default:        ;
        endcase
      end
      if (start && !active) mask <= writedata[WIDTH-1:0];

      if (done_pulse)                               done <= 1'b1;
      else if (wr_en && (address == ADDR_STATUS))   done <= 1'b0;

      if (overrun_pulse)                            overrun <= 1'b1;
      else if (wr_en && (address == ADDR_STATUS))   overrun <= 1'b0;
    end
  end

  // Read mux, zero-extended; write-only and reserved words read as 0.
  always_comb begin
    // NOTE: default assignment first so no path leaves rd_next unassigned
    // and no latch is inferred.
    rd_next = '0;
    unique case (address)
      ADDR_DATA:      rd_next[WIDTH-1:0]     = data;
      ADDR_PULSE_LEN: rd_next[CNT_WIDTH-1:0] = pulse_len;
      ADDR_IRQ_EN:    rd_next[0]             = irq_en;
      ADDR_STATUS: begin
        rd_next[STATUS_DONE]    = done;
        rd_next[STATUS_BUSY]    = active;
        rd_next[STATUS_OVERRUN] = overrun;
      end
      default:        rd_next = '0;
    endcase
  end

  // Registered read data and output port with active-pulse inversion.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
      out_port <= RESET_VALUE;
    end else begin
      readdata <= rd_next;
      out_port <= data ^ (active ? mask : '0);
    end
  end

endmodule

// File: doc/nios_ii_system_led_pulse.md
# nios_ii_system_led_pulse

Avalon-MM slave output port, the driving counterpart of the system's edge-capturing key input ports. Drives a WIDTH-bit `out_port` (LEDs, GPIO strobes) with a plain data register, atomic set/clear, and a hardware one-shot pulse timer. The one-shot temporarily inverts selected bits for a programmed number of clocks, then raises a maskable completion interrupt to the NIOS II.

## Interface
- WIDTH, 8: width of `out_port`, 1..32.
- CNT_WIDTH, 16: width of the pulse-length counter, 1..32.
- RESET_VALUE, 0: value of the data register and `out_port` after reset.

- clk  in  1  system clock; all logic on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  3  register word select.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe; a write is accepted on an edge with `chipselect && !write_n`.
- writedata  in  32  write data.
- readdata  out  32  registered read data; reset 0.
- irq  out  1  `done & irq_en`; reset 0.
- out_port  out  WIDTH  registered output; reset RESET_VALUE.

## Operation
- Register map, by address:
  - 0 DATA: R/W, WIDTH bits.
  - 1 OUTSET: W, `data |= wd`; reads 0.
  - 2 OUTCLR: W, `data &= ~wd`; reads 0.
  - 3 PULSE_LEN: R/W, CNT_WIDTH bits; reset 0.
  - 4 PULSE: W, starts a one-shot with `mask = wd[WIDTH-1:0]`; reads 0.
  - 5 IRQ_EN: R/W, bit 0; reset 0.
  - 6 STATUS: bit0 done, bit1 busy, bit2 overrun; a write of any value clears done and overrun.
  - 7: reserved; reads 0, writes ignored.
- All readback is zero-extended to 32 bits. Writes ignore bits above the register width.
- Timer FSM states:
  - IDLE to ACTIVE on an accepted PULSE write with PULSE_LEN ≠ 0. Load `cnt = PULSE_LEN`, latch `mask`.
  - PULSE write in IDLE with PULSE_LEN = 0: no pulse; done is set at that edge.
  - ACTIVE: `cnt` decrements each edge. On the edge where `cnt == 1`, go to IDLE and set done.
  - PULSE write while ACTIVE: ignored (the pulse is not restarted); sets overrun.
- Output: `out_port <= data ^ (state==ACTIVE ? mask : 0)` every edge.
- A DATA, OUTSET or OUTCLR write during a pulse takes effect immediately; the mask inversion still applies.
- A PULSE_LEN write during a pulse affects only the next pulse.
- busy = (state == ACTIVE).
- Simultaneous done-set and STATUS-write clear on the same edge: the set wins, done = 1.

## Timing
- Read latency is 1 cycle. `readdata` is registered every edge from `address`, independent of `chipselect` (matches the input-port convention).
- A data write accepted at edge k reaches `out_port` at edge k+1.
- A PULSE write accepted at edge k with LEN = L ≥ 1:
  - busy is set from edge k through edge k+L−1 and cleared at edge k+L.
  - `out_port` is inverted on mask bits from edge k+1 through edge k+L, i.e. for exactly L cycles.
  - done and irq (if enabled) assert at edge k+L.
- Maximum pulse is 2^CNT_WIDTH − 1 cycles; the counter never wraps.
- Reset asserted mid-pulse: immediately returns to IDLE and clears counter, mask, done, overrun and irq_en. `out_port` = RESET_VALUE and `readdata` = 0 asynchronously.

## Structure
- Shared package `nios_ii_system_pio_pkg` holds:
  - register address constants: ADDR_DATA, ADDR_OUTSET, ADDR_OUTCLR, ADDR_PULSE_LEN, ADDR_PULSE, ADDR_IRQ_EN, ADDR_STATUS;
  - STATUS bit positions;
  - the timer state enum {IDLE, ACTIVE}.
- One sub-module, `nios_ii_system_pulse_timer`: FSM plus down-counter.
  - Inputs: start, len.
  - Outputs: active, done_pulse, overrun_pulse.
- The top level keeps the register file, read mux, output register and sticky status bits.

## Test plan
- Reset with RESET_VALUE = 8'h5A → `out_port` = 5A, `readdata` = 0, `irq` = 0; read DATA → 0x5A.
- Write DATA = 0x0F, OUTSET 0x30, OUTCLR 0x03 → `out_port` successively 0F, 3F, 3C, each one edge after its write; reads of addresses 1 and 2 return 0.
- PULSE_LEN = 3, IRQ_EN = 1, DATA = 0x00, PULSE 0x81 at edge k → `out_port` = 81 for edges k+1..k+3, 00 at k+4; busy 1 for k..k+2; done and irq 1 at k+3; STATUS write → irq 0 next edge.
- Second PULSE write during an active pulse → pulse end time unchanged; STATUS reads 0x5 after completion (overrun + done).
- PULSE_LEN = 0, PULSE 0xFF → `out_port` never changes; done = 1 one edge later; STATUS write on the same edge as a done-set → done stays 1.
- Reset asserted at the second cycle of a PULSE_LEN = 10 pulse → `out_port` = RESET_VALUE at once; after release, STATUS = 0 and PULSE_LEN = 0.
